tick_countdown_timer: RTL
=========================

# tick_countdown_timer

Countdown timer consuming the slow square wave produced by the team's clock divider (1 Hz by default) as its time base. Synchronizes that wave into the `clk` domain, detects its rising edge, and decrements a BCD MM:SS count once per tick. Controlled by load/start/pause/clear pulses from the front-panel controller; drives BCD digits to the display stage and an expiry flag to the controller.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `tick_in`; minimum 2.

Ports:
- `clk` in 1: system clock (same clock as the divider).
- `reset` in 1: asynchronous, active-low.
- `tick_in` in 1: divider output; one rising edge per period; treated as asynchronous.
- `load` in 1: one-cycle pulse; latch the `preset_*` values into the count.
- `preset_min_t`, `preset_min_o`, `preset_sec_t`, `preset_sec_o` in 4 each: preset digits, BCD.
- `start` in 1: one-cycle pulse; begin or resume counting.
- `pause` in 1: one-cycle pulse; hold the count.
- `clear` in 1: one-cycle pulse; return to IDLE with the count at 00:00.
- `min_t`, `min_o`, `sec_t`, `sec_o` out 4 each: current count, BCD.
- `running` out 1: high while in state RUN.
- `expired` out 1: high while in state EXPIRED.
- `done` out 1: one-cycle pulse on reaching 00:00.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- Synchronizer flops reset to 1. The divider's output also resets high, so no false edge occurs after reset. `tick` = sync_last & ~sync_prev: one `clk` cycle per rising edge of `tick_in`.
- States: IDLE, RUN, PAUSE, EXPIRED. After reset: IDLE, count 00:00, all outputs 0.
- Each cycle, the first matching command applies; lower-priority commands in the same cycle are ignored.
  1. `clear`: go to IDLE from any state; count becomes 00:00.
  2. `load`: valid in IDLE, PAUSE, EXPIRED; ignored in RUN.
     - Valid preset: count = preset; state becomes IDLE.
     - Invalid preset (any digit > 9, or `preset_sec_t` > 5): count and state unchanged; `load_err` pulses.
  3. `start`: IDLE or PAUSE → RUN if count ≠ 00:00; with count 00:00 it is ignored. Ignored in RUN and EXPIRED.
  4. `pause`: RUN → PAUSE; ignored elsewhere.
  5. `tick` while in RUN: decrement the count.
- Decrement rules:
  - `sec_o`: 0 → 9 with borrow, else −1.
  - `sec_t`: on borrow, 0 → 5 with borrow, else −1.
  - `min_o`: on borrow, 0 → 9 with borrow, else −1.
  - `min_t`: on borrow, −1.
  - Maximum count is 99:59.
- If the decremented value is 00:00: go to EXPIRED and pulse `done` on that same edge.
- Count is never decremented outside RUN; the count never wraps below 00:00.
- A `tick` coincident with `start` does not decrement. The state must already be RUN before the edge.

## Timing
- All outputs are registered.
- Tick latency: the count updates on the (SYNC_STAGES+1)th `clk` rising edge after the first edge that samples `tick_in` high.
- Command latency: state and count update on the `clk` edge that samples the command pulse. `running` and `expired` reflect the new state in the following cycle.
- `done` and `load_err` are exactly one cycle wide.
- Reset asserted mid-count: immediate return to IDLE / 00:00 with all outputs 0. The synchronizer returns to all-ones.
- `tick_in` must stay high and low for ≥ SYNC_STAGES+1 `clk` cycles each. The default divider ratio satisfies this by a wide margin.

## Structure
- Shared package `timer_pkg` holds:
  - 4-bit `bcd_t`.
  - State enum `tmr_state_t` (IDLE, RUN, PAUSE, EXPIRED).
  - Constants `BCD_MAX` = 9 and `SEC_T_MAX` = 5.
- Sub-module `tick_sync_edge`: parameterized synchronizer plus rising-edge detector. Its flops reset to 1; output is a one-cycle `tick`.
- Top level holds the FSM, the BCD decrement/borrow chain, preset validation and the output registers.

## Test plan
- Reset release with `tick_in`=1 → no `tick` and no state change for 10 cycles; all outputs 0.
- Load 01:00, start, apply 1 tick → count 00:59. `running`=1 during RUN; count changes SYNC_STAGES+1 edges after `tick_in` rises.
- Load 00:02, start, apply 2 ticks → 00:01, then 00:00 with a `done` pulse of 1 cycle. `expired`=1 afterwards; further ticks leave 00:00.
- Load 10:00, start, apply 1 tick → 09:59 (full borrow chain). Then pause, apply 3 ticks → count holds at 09:59. Then start, apply 1 tick → 09:58.
- Load with preset 00:60 or 0A:00 → `load_err` pulses once; count and state unchanged. Load during RUN → ignored, no `load_err`.
- `clear` in the same cycle as `tick` in RUN → IDLE, count 00:00, no `done`. `start` with count 00:00 → remains IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, constants and BCD helpers for the MM:SS countdown timer.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } tmr_state_t;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
  } mmss_t;

  // A preset is usable only if every digit is decimal and seconds stay below 60.
  function automatic logic mmss_valid(input mmss_t c);
    return (c.min_t <= BCD_MAX) && (c.min_o <= BCD_MAX) &&
           (c.sec_o <= BCD_MAX) && (c.sec_t <= SEC_T_MAX);
  endfunction

  // One-second decrement with the borrow rippling sec_o -> sec_t -> min_o -> min_t.
  // Callers never pass 00:00, so min_t never underflows.
  function automatic mmss_t mmss_dec(input mmss_t c);
    mmss_t r;
    r = c;
    if (c.sec_o == 4'd0) begin
      r.sec_o = BCD_MAX;
      if (c.sec_t == 4'd0) begin
        r.sec_t = SEC_T_MAX;
        if (c.min_o == 4'd0) begin
          r.min_o = BCD_MAX;
          r.min_t = c.min_t - 4'd1;
        end else begin
          r.min_o = c.min_o - 4'd1;
        end
      end else begin
        r.sec_t = c.sec_t - 4'd1;
      end
    end else begin
      r.sec_o = c.sec_o - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronizes the divider's slow square wave into clk and flags its rising edge.
// All flops reset high so a divider that also resets high produces no false edge.
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the asynchronous input through the synchronizer and keep one delayed copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign tick = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/tick_countdown_timer.sv
// MM:SS BCD countdown timer driven by front-panel command pulses and a 1 Hz tick.
//
// state   | meaning
// IDLE    | count loaded or cleared, waiting for start
// RUN     | decrementing once per tick
// PAUSE   | count held, start resumes
// EXPIRED | reached 00:00, waiting for load or clear
module tick_countdown_timer
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       load,
  input  logic [3:0] preset_min_t,
  input  logic [3:0] preset_min_o,
  input  logic [3:0] preset_sec_t,
  input  logic [3:0] preset_sec_o,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       load_err
);

  tmr_state_t r_state;
  mmss_t      r_count;
  logic       r_running;
  logic       r_expired;
  logic       r_done;
  logic       r_load_err;

  logic  w_tick;
  mmss_t w_preset;
  logic  w_preset_ok;
  mmss_t w_dec;
  logic  w_count_zero;
  logic  w_dec_zero;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .tick_in (tick_in),
    .tick    (w_tick)
  );

  assign w_preset     = '{min_t: preset_min_t, min_o: preset_min_o,
                          sec_t: preset_sec_t, sec_o: preset_sec_o};
  assign w_preset_ok  = mmss_valid(w_preset);
  assign w_dec        = mmss_dec(r_count);
  assign w_count_zero = (r_count == '0);
  assign w_dec_zero   = (w_dec == '0);

  // Prioritized command handling; a command only claims the cycle when it acts in the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
      if (clear) begin
        r_state   <= IDLE;
        r_count   <= '0;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else if (load && r_state != RUN) begin
        if (w_preset_ok) begin
          r_count   <= w_preset;
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_expired <= 1'b0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (start && (r_state == IDLE || r_state == PAUSE) && !w_count_zero) begin
        r_state   <= RUN;
        r_running <= 1'b1;
      end else if (pause && r_state == RUN) begin
        r_state   <= PAUSE;
        r_running <= 1'b0;
      end else if (w_tick && r_state == RUN) begin
        r_count <= w_dec;
        if (w_dec_zero) begin
          r_state   <= EXPIRED;
          r_running <= 1'b0;
          r_expired <= 1'b1;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign min_t    = r_count.min_t;
  assign min_o    = r_count.min_o;
  assign sec_t    = r_count.sec_t;
  assign sec_o    = r_count.sec_o;
  assign running  = r_running;
  assign expired  = r_expired;
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule
